gt_link_supervisor: RTL and testbench
=====================================

// Module: gt_link_supervisor
// PURPOSE
//  Per-lane link supervisor for an N_CH-lane GT transceiver quad running 10G BASE-R PHYs.
//  Generates the shared TX userclk-active flag and synchronises per-lane reset-done and block-lock.
//  Requests a per-lane RX datapath reset when a lane fails to lock, with bounded retries.
//  Sits between the GT wizard reset controller and the per-lane PHYs, in the TX user clock domain.
// PARAMETERS
//  N_CH          2       number of lanes supervised
//  SYNC_STAGES   3       flops per async-input synchroniser (>=2)
//  LOCK_TIMEOUT  65536   cycles in WAIT_LOCK before a reset request is issued (>=2)
//  RESET_PULSE   16      cycles rx_dp_reset_req is held high per request (>=1)
//  MAX_RETRIES   7       consecutive failed reset attempts before FAIL (>=1)
//  CNT_W         16      width of each lock-loss counter (LINK_STATS_EN only)
// PORTS
//  gt_txusrclk        in   1           TX user clock; all logic on rising edge
//  gt_tx_reset        in   1           reset, asynchronous, active-high
//  tx_reset_done      in   1           GT TX reset done, async, synchronised internally
//  rx_reset_done      in   N_CH        per-lane GT RX reset done, async, synchronised
//  rx_block_lock      in   N_CH        per-lane PHY block lock, async (RX domain), synchronised
//  userclk_tx_active  out  1           TX user clock running; to GT wizard
//  rx_dp_reset_req    out  N_CH        per-lane RX datapath reset request, RESET_PULSE cycles
//  link_up            out  N_CH        lane in UP state
//  retry_exhausted    out  N_CH        lane in FAIL state
//  lock_loss_count    out  N_CH*CNT_W  lane i at [i*CNT_W +: CNT_W]; LINK_STATS_EN only
// BEHAVIOUR
//  - Reset: all outputs 0, all synchronisers 0, FSMs IDLE, timers/retry counts 0.
//  - userclk_tx_active: registered; 1 on first edge after gt_tx_reset deasserts, then held.
//  - Inputs pass SYNC_STAGES flops; "td","rd","lk" below are synchronised values.
//  - Per-lane FSM (outputs registered, one cycle after state entry):
//    IDLE:      timer=0; td&rd[i] -> WAIT_LOCK.
//    WAIT_LOCK: timer++; lk[i] -> UP (retry=0); else timer==LOCK_TIMEOUT-1 -> RESET.
//               lk and timeout in same cycle: UP wins.
//    RESET:     rx_dp_reset_req[i]=1 for RESET_PULSE cycles; then retry++;
//               retry reaches MAX_RETRIES -> FAIL, else IDLE.
//    UP:        link_up[i]=1; lk[i] falls -> WAIT_LOCK, timer=0.
//    FAIL:      retry_exhausted[i]=1; held until rd[i] falls -> IDLE, retry=0.
//  - rd[i] or td low in IDLE/WAIT_LOCK/UP -> IDLE next cycle. In RESET the pulse always completes.
//  - Timer width clog2(LOCK_TIMEOUT); never wraps, cleared on every WAIT_LOCK entry.
//  - Retry count width clog2(MAX_RETRIES+1); saturates in FAIL.
//  - Lanes fully independent; no arbitration between simultaneous requests.
//  - gt_tx_reset mid-operation: immediate return to reset values, including an active pulse.
// CONFIGURATION
//  GT_LINK_STATS_EN defined: lock_loss_count[i] += 1 on each UP->WAIT_LOCK transition.
//    Saturates at all-ones; cleared only by gt_tx_reset.
//  Undefined: port lock_loss_count and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package gt_link_pkg: lane_state_e {IDLE,WAIT_LOCK,RESET,UP,FAIL}, and width functions
//    TMR_W(LOCK_TIMEOUT), RTY_W(MAX_RETRIES), PLS_W(RESET_PULSE).
//  Sub-module gt_link_lane_fsm: one lane FSM + timer + retry (+ stats counter); generate N_CH copies.
//  Top holds the synchronisers and userclk_tx_active.
// TESTING  (LOCK_TIMEOUT=64, RESET_PULSE=4, MAX_RETRIES=2, N_CH=2, SYNC_STAGES=3)
//  1. Release gt_tx_reset -> userclk_tx_active=1 next edge; all other outputs 0.
//  2. td=rd=1, lane0 lock at cycle 10 -> link_up[0]=1 within SYNC_STAGES+2 cycles; no reset req.
//  3. Lane1 never locks -> rx_dp_reset_req[1] high exactly 4 cycles, 64 cycles after WAIT_LOCK entry.
//     Second attempt also fails -> retry_exhausted[1]=1; lane0 unaffected.
//  4. Lock arrives same cycle as timeout -> UP, no reset request.
//     Drop rd[1] in FAIL -> IDLE, retry cleared.
//  5. Assert gt_tx_reset mid reset pulse -> rx_dp_reset_req=0 immediately.
//     With GT_LINK_STATS_EN: 3 lock drops -> lock_loss_count[0]=3.
//     Force count near all-ones -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/gt_link_pkg.sv
// Shared types and width helpers for the GT link supervisor.
// GT_LINK_STATS_EN (when defined) adds per-lane lock-loss counters.
package gt_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    RESET,
    UP,
    FAIL
  } lane_state_e;

  function automatic int TMR_W(input int lock_timeout);
    return (lock_timeout > 2) ? $clog2(lock_timeout) : 1;
  endfunction

  function automatic int RTY_W(input int max_retries);
    return $clog2(max_retries + 1);
  endfunction

  function automatic int PLS_W(input int reset_pulse);
    return (reset_pulse > 2) ? $clog2(reset_pulse) : 1;
  endfunction

endpackage

// File: rtl/gt_link_lane_fsm.sv
// One lane of the supervisor: state machine, lock timer, retry count.
// GT_LINK_STATS_EN adds a saturating lock-loss counter.
module gt_link_lane_fsm
  import gt_link_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RESET_PULSE  = 16,
  parameter int MAX_RETRIES  = 7
`ifdef GT_LINK_STATS_EN
  , parameter int CNT_W      = 16
`endif
) (
  input  logic gt_txusrclk,
  input  logic gt_tx_reset,
  input  logic td,
  input  logic rd,
  input  logic lk,
  output logic rx_dp_reset_req,
  output logic link_up,
  output logic retry_exhausted
`ifdef GT_LINK_STATS_EN
  , output logic [CNT_W-1:0] lock_loss_count
`endif
);

  localparam int TW = TMR_W(LOCK_TIMEOUT);
  localparam int RW = RTY_W(MAX_RETRIES);
  localparam int PW = PLS_W(RESET_PULSE);
  localparam logic [TW-1:0] TMR_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [PW-1:0] PLS_LAST = PW'(RESET_PULSE - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  lane_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [PW-1:0] pls_q, pls_d;
  logic          req_q, link_up_q, exhausted_q;
  logic          link_ok;
`ifdef GT_LINK_STATS_EN
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
`endif

  assign link_ok = td & rd;

  // NOTE: every _d gets its default first, so no branch can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    pls_d   = pls_q;
`ifdef GT_LINK_STATS_EN
    loss_cnt_d = loss_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (link_ok) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock beats timeout when both land on the same cycle.
        if (!link_ok) begin
          state_d = IDLE;
        end else if (lk) begin
          state_d = UP;
          retry_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = RESET;
          pls_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESET: begin
        // The pulse always runs to completion; loss of td/rd is seen afterwards.
        if (pls_q == PLS_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RTY_MAX) ? FAIL : IDLE;
        end else begin
          pls_d = pls_q + 1'b1;
        end
      end
      UP: begin
        if (!link_ok) begin
          state_d = IDLE;
        end else if (!lk) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
`ifdef GT_LINK_STATS_EN
          if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
`endif
        end
      end
      FAIL: begin
        if (!rd) begin
          state_d = IDLE;
          retry_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only; blocking here would race with readers of _q.
  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      pls_q       <= '0;
      req_q       <= 1'b0;
      link_up_q   <= 1'b0;
      exhausted_q <= 1'b0;
`ifdef GT_LINK_STATS_EN
      loss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pls_q       <= pls_d;
      req_q       <= (state_d == RESET);
      link_up_q   <= (state_d == UP);
      exhausted_q <= (state_d == FAIL);
`ifdef GT_LINK_STATS_EN
      loss_cnt_q  <= loss_cnt_d;
`endif
    end
  end

  assign rx_dp_reset_req = req_q;
  assign link_up         = link_up_q;
  assign retry_exhausted = exhausted_q;
`ifdef GT_LINK_STATS_EN
  assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: rtl/gt_link_supervisor.sv
// Per-lane link supervisor: input synchronisers, userclk-active flag, N_CH lane FSMs.
// GT_LINK_STATS_EN adds the lock_loss_count port and counters.
module gt_link_supervisor
  import gt_link_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int SYNC_STAGES  = 3,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RESET_PULSE  = 16,
  parameter int MAX_RETRIES  = 7
`ifdef GT_LINK_STATS_EN
  , parameter int CNT_W      = 16
`endif
) (
  input  logic            gt_txusrclk,
  input  logic            gt_tx_reset,
  input  logic            tx_reset_done,
  input  logic [N_CH-1:0] rx_reset_done,
  input  logic [N_CH-1:0] rx_block_lock,
  output logic            userclk_tx_active,
  output logic [N_CH-1:0] rx_dp_reset_req,
  output logic [N_CH-1:0] link_up,
  output logic [N_CH-1:0] retry_exhausted
`ifdef GT_LINK_STATS_EN
  , output logic [N_CH*CNT_W-1:0] lock_loss_count
`endif
);

  logic [SYNC_STAGES-1:0] td_sync_q, td_sync_d;
  logic [N_CH-1:0]        rd_sync_q [SYNC_STAGES];
  logic [N_CH-1:0]        rd_sync_d [SYNC_STAGES];
  logic [N_CH-1:0]        lk_sync_q [SYNC_STAGES];
  logic [N_CH-1:0]        lk_sync_d [SYNC_STAGES];
  logic                   userclk_active_q, userclk_active_d;
  logic                   td;
  logic [N_CH-1:0]        rd, lk;

  always_comb begin
    userclk_active_d = 1'b1;
    td_sync_d        = {td_sync_q[SYNC_STAGES-2:0], tx_reset_done};
    rd_sync_d[0]     = rx_reset_done;
    lk_sync_d[0]     = rx_block_lock;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      rd_sync_d[s] = rd_sync_q[s-1];
      lk_sync_d[s] = lk_sync_q[s-1];
    end
  end

  // NOTE: the synchroniser chains are reset like any other state, so a stale 1
  // left over from before reset can never fake done or lock.
  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      userclk_active_q <= 1'b0;
      td_sync_q        <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        rd_sync_q[s] <= '0;
        lk_sync_q[s] <= '0;
      end
    end else begin
      userclk_active_q <= userclk_active_d;
      td_sync_q        <= td_sync_d;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        rd_sync_q[s] <= rd_sync_d[s];
        lk_sync_q[s] <= lk_sync_d[s];
      end
    end
  end

  assign userclk_tx_active = userclk_active_q;
  assign td = td_sync_q[SYNC_STAGES-1];
  assign rd = rd_sync_q[SYNC_STAGES-1];
  assign lk = lk_sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    gt_link_lane_fsm #(
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .RESET_PULSE  (RESET_PULSE),
      .MAX_RETRIES  (MAX_RETRIES)
`ifdef GT_LINK_STATS_EN
      , .CNT_W      (CNT_W)
`endif
    ) u_lane (
      .gt_txusrclk     (gt_txusrclk),
      .gt_tx_reset     (gt_tx_reset),
      .td              (td),
      .rd              (rd[i]),
      .lk              (lk[i]),
      .rx_dp_reset_req (rx_dp_reset_req[i]),
      .link_up         (link_up[i]),
      .retry_exhausted (retry_exhausted[i])
`ifdef GT_LINK_STATS_EN
      , .lock_loss_count (lock_loss_count[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_gt_link_supervisor.sv
// Directed bench for gt_link_supervisor (LOCK_TIMEOUT=64, RESET_PULSE=4, MAX_RETRIES=2).
// Stats checks compile in only when GT_LINK_STATS_EN is defined.
module tb_gt_link_supervisor;

  logic       gt_txusrclk = 1'b0;
  logic       gt_tx_reset;
  logic       tx_reset_done;
  logic [1:0] rx_reset_done;
  logic [1:0] rx_block_lock;
  logic       userclk_tx_active;
  logic [1:0] rx_dp_reset_req;
  logic [1:0] link_up;
  logic [1:0] retry_exhausted;
`ifdef GT_LINK_STATS_EN
  logic [31:0] lock_loss_count;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  gt_link_supervisor #(
    .N_CH         (2),
    .SYNC_STAGES  (3),
    .LOCK_TIMEOUT (64),
    .RESET_PULSE  (4),
    .MAX_RETRIES  (2)
  ) dut (
    .gt_txusrclk       (gt_txusrclk),
    .gt_tx_reset       (gt_tx_reset),
    .tx_reset_done     (tx_reset_done),
    .rx_reset_done     (rx_reset_done),
    .rx_block_lock     (rx_block_lock),
    .userclk_tx_active (userclk_tx_active),
    .rx_dp_reset_req   (rx_dp_reset_req),
    .link_up           (link_up),
    .retry_exhausted   (retry_exhausted)
`ifdef GT_LINK_STATS_EN
    , .lock_loss_count (lock_loss_count)
`endif
  );

  always #5 gt_txusrclk = ~gt_txusrclk;

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge gt_txusrclk);
    @(negedge gt_txusrclk);
    cyc++;
  endtask

  task automatic test_reset();
    gt_tx_reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({userclk_tx_active, rx_dp_reset_req, link_up, retry_exhausted} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {userclk_tx_active, rx_dp_reset_req, link_up, retry_exhausted});
    end
    gt_tx_reset = 1'b0;
    tick();
    vectors++;
    if (userclk_tx_active !== 1'b1) begin
      miscompares++;
      $display("FAIL userclk_active_after_release: got %b want 1", userclk_tx_active);
    end
    vectors++;
    if ({rx_dp_reset_req, link_up, retry_exhausted} !== 6'b0) begin
      miscompares++;
      $display("FAIL others_after_release: got %b want 000000",
               {rx_dp_reset_req, link_up, retry_exhausted});
    end
  endtask

  // Lane 0 locks at cycle 10; lane 1 never locks.
  task automatic test_lock_up();
    int up_cyc = -1;
    bit req_seen = 1'b0;
    tx_reset_done = 1'b1;
    rx_reset_done = 2'b11;
    cyc = 0;
    while (cyc < 20) begin
      if (cyc == 10) rx_block_lock[0] = 1'b1;
      tick();
      if (link_up[0] && up_cyc < 0) up_cyc = cyc;
      if (rx_dp_reset_req !== 2'b00) req_seen = 1'b1;
    end
    vectors++;
    if (up_cyc <= 10 || up_cyc > 15) begin
      miscompares++;
      $display("FAIL lane0_up_latency: got cycle %0d want 11..15", up_cyc);
    end
    vectors++;
    if (req_seen) begin
      miscompares++;
      $display("FAIL lane0_no_req: got request want none");
    end
    vectors++;
    if (link_up[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL lane1_not_up: got %b want 0", link_up[1]);
    end
  endtask

  // Lane 1: WAIT_LOCK entered at cycle 4, timeouts at 68 and 137, FAIL at 141.
  task automatic test_retry();
    int rise[2] = '{-1, -1};
    int n_rise = 0, high = 0, exh_cyc = -1;
    bit prev = 1'b0, lane0_bad = 1'b0;
    while (cyc < 160) begin
      tick();
      if (rx_dp_reset_req[1] && !prev && n_rise < 2) begin
        rise[n_rise] = cyc;
        n_rise++;
      end
      if (rx_dp_reset_req[1]) high++;
      prev = rx_dp_reset_req[1];
      if (retry_exhausted[1] && exh_cyc < 0) exh_cyc = cyc;
      if (link_up[0] !== 1'b1 || rx_dp_reset_req[0] !== 1'b0) lane0_bad = 1'b1;
    end
    vectors++;
    if (rise[0] != 68) begin
      miscompares++;
      $display("FAIL first_req_cycle: got %0d want 68", rise[0]);
    end
    vectors++;
    if (rise[1] != 137) begin
      miscompares++;
      $display("FAIL second_req_cycle: got %0d want 137", rise[1]);
    end
    vectors++;
    if (high != 8) begin
      miscompares++;
      $display("FAIL req_high_cycles: got %0d want 8", high);
    end
    vectors++;
    if (exh_cyc != 141) begin
      miscompares++;
      $display("FAIL exhausted_cycle: got %0d want 141", exh_cyc);
    end
    vectors++;
    if (lane0_bad) begin
      miscompares++;
      $display("FAIL lane0_unaffected: got disturbance want steady up");
    end
  endtask

  // Drop lock on lane 0 and restore it so the sync'd lock meets the timeout edge.
  task automatic test_lock_at_timeout();
    int down_k = -1, up_k = -1;
    bit req_seen = 1'b0;
    rx_block_lock[0] = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      tick();
      if (k == 64) rx_block_lock[0] = 1'b1;
      if (!link_up[0] && down_k < 0) down_k = k;
      if (link_up[0] && down_k > 0 && up_k < 0) up_k = k;
      if (rx_dp_reset_req[0]) req_seen = 1'b1;
    end
    vectors++;
    if (down_k != 4) begin
      miscompares++;
      $display("FAIL lock_drop_latency: got %0d want 4", down_k);
    end
    vectors++;
    if (up_k != 68) begin
      miscompares++;
      $display("FAIL lock_at_timeout_up: got %0d want 68", up_k);
    end
    vectors++;
    if (req_seen) begin
      miscompares++;
      $display("FAIL lock_at_timeout_no_req: got request want none");
    end
  endtask

  // rd[1] low in FAIL -> IDLE with retry cleared: two full attempts needed again.
  task automatic test_fail_recover();
    int clr_k = -1, rise_k = -1, exh_k = -1;
    rx_reset_done[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (!retry_exhausted[1] && clr_k < 0) clr_k = k;
    end
    vectors++;
    if (clr_k != 4) begin
      miscompares++;
      $display("FAIL fail_exit_latency: got %0d want 4", clr_k);
    end
    rx_reset_done[1] = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (rx_dp_reset_req[1] && rise_k < 0) rise_k = k;
      if (retry_exhausted[1] && exh_k < 0) exh_k = k;
    end
    vectors++;
    if (rise_k != 68) begin
      miscompares++;
      $display("FAIL recover_first_req: got %0d want 68", rise_k);
    end
    vectors++;
    if (exh_k != 141) begin
      miscompares++;
      $display("FAIL recover_exhausted: got %0d want 141", exh_k);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int wait_k = 0;
    rx_reset_done[1] = 1'b0;
    repeat (6) tick();
    rx_reset_done[1] = 1'b1;
    while (!rx_dp_reset_req[1] && wait_k < 100) begin
      tick();
      wait_k++;
    end
    vectors++;
    if (rx_dp_reset_req[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL pulse_timeout: got no request within 100 cycles want request");
    end
    tick();
    gt_tx_reset = 1'b1;
    #1;
    vectors++;
    if ({userclk_tx_active, rx_dp_reset_req, link_up, retry_exhausted} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid_pulse: got %b want 0000000",
               {userclk_tx_active, rx_dp_reset_req, link_up, retry_exhausted});
    end
    tick();
    gt_tx_reset = 1'b0;
    tick();
    vectors++;
    if (userclk_tx_active !== 1'b1 || link_up[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_sync_clear: got active=%b up0=%b want active=1 up0=0",
               userclk_tx_active, link_up[0]);
    end
  endtask

`ifdef GT_LINK_STATS_EN
  task automatic drop_lane0_lock();
    rx_block_lock[0] = 1'b0;
    repeat (6) tick();
    rx_block_lock[0] = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_stats();
    int wait_k = 0;
    vectors++;
    if (lock_loss_count !== 32'h0) begin
      miscompares++;
      $display("FAIL stats_after_reset: got %h want 00000000", lock_loss_count);
    end
    while (!link_up[0] && wait_k < 10) begin
      tick();
      wait_k++;
    end
    repeat (3) drop_lane0_lock();
    vectors++;
    if (lock_loss_count !== 32'h0000_0003) begin
      miscompares++;
      $display("FAIL stats_three_drops: got %h want 00000003", lock_loss_count);
    end
    force dut.g_lane[0].u_lane.loss_cnt_q = 16'hFFFD;
    tick();
    release dut.g_lane[0].u_lane.loss_cnt_q;
    repeat (3) drop_lane0_lock();
    vectors++;
    if (lock_loss_count[15:0] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL stats_saturate: got %h want ffff", lock_loss_count[15:0]);
    end
  endtask
`endif

  initial begin
    gt_tx_reset   = 1'b1;
    tx_reset_done = 1'b0;
    rx_reset_done = 2'b00;
    rx_block_lock = 2'b00;
    test_reset();
    test_lock_up();
    test_retry();
    test_lock_at_timeout();
    test_fail_recover();
    test_reset_mid_pulse();
`ifdef GT_LINK_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
